// File: rtl/wb_tlb_commit.sv
// WB-stage TLB maintenance commit: tlbrd/tlbwr/tlbfill issue in one cycle,
// invtlb sweeps every entry through the read/write ports, one per cycle.
module wb_tlb_commit #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_invop,
  input  logic [9:0]        req_asid,
  input  logic [18:0]       req_vppn,
  input  logic [31:0]       req_pc,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  csr_tlbidx_index,
  input  logic              csr_tlbidx_ne,
  input  logic [5:0]        csr_estat_ecode,
  input  logic [88:0]       csr_entry,
  output logic [IDX_W-1:0]  tlb_r_index,
  input  logic [88:0]       tlb_r_entry,
  output logic              tlb_we,
  output logic [IDX_W-1:0]  tlb_w_index,
  output logic [88:0]       tlb_w_entry,
  output logic              rd_valid,
  output logic [88:0]       rd_entry,
  output logic              reflush,
  output logic [31:0]       reflush_pc
);

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } op_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam logic [15:0]      LFSR_SEED = 16'hACE1;
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(TLBNUM - 1);

  state_e           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [15:0]      lfsr, lfsr_next;
  logic             lfsr_adv;
  logic             rd_fire;
  logic             done;
  logic [31:0]      done_pc;
  logic             inv_accept;
  logic             match;

  logic [2:0]       inv_op;
  logic [9:0]       inv_asid;
  logic [18:0]      inv_vppn;
  logic [31:0]      inv_pc;

  tlb_entry_t       r_ent, c_ent, w_ent;

  assign r_ent       = tlb_entry_t'(tlb_r_entry);
  assign c_ent       = tlb_entry_t'(csr_entry);
  assign tlb_w_entry = w_ent;
  assign lfsr_next   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

  // invtlb selection on the entry currently being swept, against latched operands.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    match = 1'b0;
    unique case (inv_op)
      3'd0, 3'd1: match = 1'b1;
      3'd2:       match = r_ent.g;
      3'd3:       match = !r_ent.g;
      3'd4:       match = !r_ent.g && (r_ent.asid == inv_asid);
      3'd5:       match = !r_ent.g && (r_ent.asid == inv_asid) && (r_ent.vppn == inv_vppn);
      3'd6:       match = (r_ent.g || (r_ent.asid == inv_asid)) && (r_ent.vppn == inv_vppn);
      default:    match = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    req_ready   = 1'b1;
    tlb_we      = 1'b0;
    tlb_r_index = csr_tlbidx_index;
    tlb_w_index = csr_tlbidx_index;
    w_ent       = c_ent;
    w_ent.e     = (csr_estat_ecode == 6'h3F) || !csr_tlbidx_ne;
    lfsr_adv    = 1'b0;
    rd_fire     = 1'b0;
    done        = 1'b0;
    done_pc     = req_pc + 32'd4;
    inv_accept  = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          unique case (req_op)
            OP_RD: begin
              rd_fire = 1'b1;
              done    = 1'b1;
            end
            OP_WR: begin
              tlb_we = 1'b1;
              done   = 1'b1;
            end
            OP_FILL: begin
              tlb_we      = 1'b1;
              tlb_w_index = lfsr[IDX_W-1:0];
              lfsr_adv    = 1'b1;
              done        = 1'b1;
            end
            OP_INV: begin
              if (req_invop <= 5'd6) begin
                req_ready  = 1'b0;
                inv_accept = 1'b1;
                idx_next   = '0;
                state_next = SWEEP;
              end else begin
                done = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      SWEEP: begin
        tlb_r_index = idx;
        tlb_w_index = idx;
        w_ent       = r_ent;
        w_ent.e     = 1'b0;
        tlb_we      = match && r_ent.e;
        req_ready   = 1'b0;
        done_pc     = inv_pc + 32'd4;
        if (idx == IDX_LAST) begin
          req_ready  = 1'b1;
          done       = 1'b1;
          idx_next   = '0;
          state_next = IDLE;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase

    // A sweep interrupted by reset must not touch the entry under the cursor.
    if (reset) tlb_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      lfsr       <= LFSR_SEED;
      rd_valid   <= 1'b0;
      rd_entry   <= '0;
      reflush    <= 1'b0;
      reflush_pc <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      rd_valid <= rd_fire;
      reflush  <= done;
      if (lfsr_adv) lfsr <= lfsr_next;
      if (rd_fire)  rd_entry <= tlb_r_entry;
      if (done)     reflush_pc <= done_pc;
    end
  end

  // NOTE: operand latches carry no reset; they are only read in SWEEP, which is always entered through a load.
  always_ff @(posedge clk) begin
    if (inv_accept) begin
      inv_op   <= req_invop[2:0];
      inv_asid <= req_asid;
      inv_vppn <= req_vppn;
      inv_pc   <= req_pc;
    end
  end

endmodule

// File: doc/wb_tlb_commit.md
# wb_tlb_commit

Parametrised TLB-maintenance commit unit for the WB stage of the LoongArch pipeline. It takes TLB instructions (tlbrd, tlbwr, tlbfill, invtlb) committing in WB, drives the TLB read and write ports, and holds WB off with `req_ready` while multi-cycle operations run. It generalises the WB-stage TLB handling to any power-of-two entry count. Compared with that handling it adds:
- a deterministic LFSR fill index in place of a simulation-only random source;
- a per-entry invtlb sweep engine covering ops 0–6;
- a registered tlbrd result;
- a refetch-request pulse.

## Interface
Parameters:
- `TLBNUM`, default 16: TLB entry count; power of two, 4..64.
- `IDX_W`, default $clog2(TLBNUM): index width; derived, never overridden.

Packed entry format `ENTRY`, 89 bits, MSB first: {e, vppn[18:0], ps[5:0], asid[9:0], g, ppn0[19:0], plv0[1:0], mat0[1:0], d0, v0, ppn1[19:0], plv1[1:0], mat1[1:0], d1, v1}.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: WB holds a valid TLB op. Already qualified by ws_valid and by the absence of a WB exception.
- `req_op` in 3: operation select; 1 = tlbrd, 2 = tlbwr, 3 = tlbfill, 4 = invtlb. Other codes complete as no-ops.
- `req_invop` in 5: invtlb op code.
- `req_asid` in 10: rj[9:0] operand for invtlb.
- `req_vppn` in 19: rk[31:13] operand for invtlb.
- `req_pc` in 32: PC of the op.
- `req_ready` out 1: op completes this cycle; ANDed into ws_ready_go.
- `csr_tlbidx_index` in IDX_W: TLBIDX.Index.
- `csr_tlbidx_ne` in 1: TLBIDX.NE.
- `csr_estat_ecode` in 6: ESTAT.Ecode.
- `csr_entry` in 89: entry assembled from TLBEHI/TLBIDX.PS/ASID/TLBELO0/TLBELO1. Its `e` field is ignored.
- `tlb_r_index` out IDX_W: TLB read index; the TLB read is combinational.
- `tlb_r_entry` in 89: TLB read data.
- `tlb_we` out 1: TLB write strobe.
- `tlb_w_index` out IDX_W: TLB write index.
- `tlb_w_entry` out 89: TLB write data.
- `rd_valid` out 1: one-cycle pulse; `rd_entry` is valid for the CSR file to load.
- `rd_entry` out 89: registered tlbrd result.
- `reflush` out 1: one-cycle pulse requesting refetch from `reflush_pc`.
- `reflush_pc` out 32: req_pc + 4 of the completed op.

## Operation
FSM states: IDLE, SWEEP.

IDLE with `req_valid`:
- tlbrd:
  - `tlb_r_index` = `csr_tlbidx_index`; `req_ready` = 1.
  - Next cycle: `rd_valid` = 1 and `rd_entry` = captured `tlb_r_entry`.
  - When the captured e = 0, the CSR side clears the fields; this block passes the entry through unchanged.
- tlbwr: `tlb_we` = 1, `tlb_w_index` = `csr_tlbidx_index`, `req_ready` = 1.
- tlbfill: as tlbwr, except `tlb_w_index` = `lfsr[IDX_W-1:0]`.
- Written `e` field (tlbwr and tlbfill):
  - e = 1 when `csr_estat_ecode` == 6'h3F;
  - otherwise e = ~`csr_tlbidx_ne`.
- invtlb with `req_invop` ≤ 6:
  - `req_ready` = 0; go to SWEEP with counter `idx` = 0.
  - Latch `req_invop`, `req_asid`, `req_vppn` and `req_pc`.
- invtlb with `req_invop` > 6: `req_ready` = 1; no TLB write. INE is raised upstream.
- Unused op codes: `req_ready` = 1; no side effects.

SWEEP, one entry per cycle:
- `tlb_r_index` = `idx`.
- match(entry), where G = g, A = asid == latched asid, V = vppn == latched vppn:
  - op 0 or 1: always;
  - op 2: G;
  - op 3: !G;
  - op 4: !G && A;
  - op 5: !G && A && V;
  - op 6: (G || A) && V.
- If match and e = 1: `tlb_we` = 1, `tlb_w_index` = `idx`, `tlb_w_entry` = `tlb_r_entry` with e = 0.
- When `idx` == TLBNUM-1: `req_ready` = 1 and return to IDLE. Otherwise increment `idx`.

LFSR:
- 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
- Reset seed 16'hACE1.
- Advances on every tlbfill completion only, so the sequence is deterministic per program.

`reflush`:
- Pulses in the cycle after any tlbrd, tlbwr, tlbfill or invtlb completion (`req_valid && req_ready`), including invtlb with an invalid op code.
- `reflush_pc` is registered together with the pulse.

`tlb_w_entry` equals `csr_entry` (with the computed e) whenever the FSM is not in SWEEP.

## Timing
- Reset values:
  - state IDLE, `idx` 0, `lfsr` 16'hACE1;
  - `rd_valid` 0, `rd_entry` 0, `reflush` 0, `reflush_pc` 0;
  - `tlb_we` 0; `req_ready` 1 when `req_valid` = 0.
- Latency:
  - tlbrd, tlbwr, tlbfill: 1 cycle, zero stall.
  - invtlb: TLBNUM+1 cycles (accept cycle plus TLBNUM sweep cycles). `req_ready` rises in the last sweep cycle.
- `req_*` inputs are stable while `req_valid` is high and `req_ready` is low. Only values latched at invtlb accept are used during SWEEP.
- `req_valid` dropping mid-SWEEP (not legal) is ignored; the sweep runs to completion.
- Reset asserted mid-SWEEP: return to IDLE the next cycle. Entries already invalidated stay invalidated; no `reflush` pulse.
- `tlb_we` is never asserted in a cycle without a valid op.

## Test plan
- TLBNUM=16, tlbwr with index 5, ne=0, ecode 0 → `tlb_we` = 1 for exactly 1 cycle at index 5 with e = 1; `reflush` next cycle with `reflush_pc` = `req_pc` + 4.
- Three tlbfill ops after reset, ecode 6'h3F, ne=1 → written indices follow the LFSR sequence from 16'hACE1, taking the low 4 bits of each successive state; e = 1 each time.
- tlbrd at index 3 holding a known entry → `rd_valid` pulses one cycle later with `rd_entry` equal to that entry.
- invtlb op 5, asid 0x12, vppn 0x40: entries 2 (g=0, asid 0x12, vppn 0x40), 7 (g=1, same asid and vppn) and 9 (g=0, asid 0x13) → only entry 2 is cleared. `req_ready` is low for 16 cycles, then high; total 17 cycles.
- invtlb op 0 with TLBNUM=32 → all valid entries cleared; 33-cycle occupancy. Op 7 → `req_ready` = 1 immediately, no writes, `reflush` still pulses.
- Reset asserted on sweep cycle 4 → next cycle state IDLE, no `reflush` pulse, `lfsr` = 16'hACE1; entries 0–3 stay cleared.
